mips_main_control_fsm: RTL and testbench
========================================

Name: mips_main_control_fsm

Overview:
- Multi-cycle main control unit. Decodes the instruction held in the memory instruction register and sequences the fetch stage, register file, ALU and memory one state per clock.
- Drives the fetch stage controls PC_LOAD, IorD, IR_EN, EPC_EN and PC_SEL.
- Handles undefined-opcode and arithmetic-overflow exceptions.
- Counts retired instructions.

Parameters:
- CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- OPCODE  in  6  Instr[31:26] from the instruction register.
- FUNCT  in  6  Instr[5:0].
- ZERO  in  1  ALU zero flag, combinational, current cycle.
- OVERFLOW  in  1  ALU signed overflow, combinational, current cycle.
- PC_LOAD  out  1  PC register enable.
- IorD  out  1  memory address select: 0 = PC, 1 = ALU register.
- IR_EN  out  1  instruction register enable.
- EPC_EN  out  1  EPC capture enable.
- PC_SEL  out  3  next-PC select:
  - 0 = ALU_OUT
  - 1 = ALU_REG_OUT
  - 2 = jump concat
  - 3 = Reg1_Out
  - 4 = zero vector
- MEM_WE  out  1  data memory write.
- REG_WE  out  1  register file write.
- REG_DST  out  1  0 = rt, 1 = rd.
- MEM_TO_REG  out  1  0 = ALU register, 1 = memory data register.
- ALU_SRC_A  out  1  0 = PC, 1 = Reg1.
- ALU_SRC_B  out  2  0 = Reg2, 1 = constant 4, 2 = sign-extended immediate, 3 = sign-extended immediate shifted left 2.
- ALU_OP  out  2  0 = add, 1 = sub, 2 = use FUNCT.
- CAUSE_EN  out  1  cause register write.
- CAUSE  out  1  0 = undefined opcode, 1 = overflow.
- INSTR_CNT  out  CNT_WIDTH  retired-instruction count.

Behaviour:
- State register updates on the CLK rising edge. RST=1 at an edge forces state FETCH and INSTR_CNT=0.
- While RST=1, every enable is forced to 0 combinationally: PC_LOAD, IR_EN, EPC_EN, MEM_WE, REG_WE, CAUSE_EN. All select outputs are 0 during reset.
- Outputs are a Moore decode of the state, except PC_LOAD in BRANCH, which depends on ZERO.
- Any signal not listed for a state is 0.
- Opcodes: R=0x00, lw=0x23, sw=0x2B, beq=0x04, j=0x02, addi=0x08. jr is R-type with FUNCT=0x08. add/sub (FUNCT 0x20/0x22) are overflow-checked.
- States, with asserted controls and next state:
  - FETCH: IorD=0, IR_EN=1, ALU_SRC_A=0, ALU_SRC_B=1, ALU_OP=0, PC_SEL=0, PC_LOAD=1. Next: DECODE.
  - DECODE: ALU_SRC_A=0, ALU_SRC_B=3, ALU_OP=0 (branch target into ALU register). Next:
    - lw or sw -> MEM_ADDR
    - R with FUNCT=0x08 -> JR
    - other R -> EXEC
    - beq -> BRANCH
    - j -> JUMP
    - addi -> ADDI_EXEC
    - any other opcode -> EXC with CAUSE=0
  - MEM_ADDR: ALU_SRC_A=1, ALU_SRC_B=2, ALU_OP=0. Next: MEM_RD for lw, MEM_WR for sw.
  - MEM_RD: IorD=1. Next: MEM_WB.
  - MEM_WB: REG_WE=1, REG_DST=0, MEM_TO_REG=1. Next: FETCH. Retires.
  - MEM_WR: IorD=1, MEM_WE=1. Next: FETCH. Retires.
  - EXEC: ALU_SRC_A=1, ALU_SRC_B=0, ALU_OP=2. Next: EXC with CAUSE=1 if OVERFLOW=1 and FUNCT is 0x20 or 0x22, otherwise ALU_WB.
  - ALU_WB: REG_WE=1, REG_DST=1, MEM_TO_REG=0. Next: FETCH. Retires.
  - ADDI_EXEC: ALU_SRC_A=1, ALU_SRC_B=2, ALU_OP=0. Next: EXC with CAUSE=1 if OVERFLOW=1, otherwise ADDI_WB.
  - ADDI_WB: REG_WE=1, REG_DST=0. Next: FETCH. Retires.
  - BRANCH: ALU_SRC_A=1, ALU_SRC_B=0, ALU_OP=1, PC_SEL=1, PC_LOAD=ZERO. Next: FETCH. Retires.
  - JUMP: PC_SEL=2, PC_LOAD=1. Next: FETCH. Retires.
  - JR: PC_SEL=3, PC_LOAD=1. Next: FETCH. Retires.
  - EXC: EPC_EN=1, CAUSE_EN=1, CAUSE as latched on entry, PC_SEL=4, PC_LOAD=1. Next: FETCH. Does not retire.
- EPC captures the current PC, i.e. the faulting address + 4.
- CAUSE is held in an internal 1-bit register, written on the transition into EXC.
- Retiring: INSTR_CNT increments by 1 on the edge leaving the retiring state. It wraps modulo 2^CNT_WIDTH.
- Cycle counts: lw 5, sw 4, R 4, addi 4, beq 3, j 3, jr 3, exception 3 (FETCH, DECODE or EXEC, EXC; overflow path 4).
- No illegal-state lockup: unreachable state encodings go to FETCH on the next edge.
- RST mid-instruction: on the next edge the state is FETCH with no partial write. Enables are already 0 during the reset cycle.

Test Plan:
- Reset held 2 cycles, then released with OPCODE=0x23 -> states FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB. REG_WE=1 and MEM_TO_REG=1 only in cycle 5. INSTR_CNT=1.
- beq with ZERO=0, then beq with ZERO=1 -> PC_LOAD=0 then 1 in BRANCH, PC_SEL=1. Each takes 3 cycles. INSTR_CNT increments by 2.
- R-type FUNCT=0x20 with OVERFLOW=1 in EXEC -> no REG_WE. EXC asserts EPC_EN=1, CAUSE_EN=1, CAUSE=1, PC_SEL=4, PC_LOAD=1. INSTR_CNT unchanged.
- OPCODE=0x3F -> DECODE then EXC with CAUSE=0. Then FETCH.
- j, then jr (OPCODE 0, FUNCT 0x08) -> PC_SEL=2 and 3 respectively, PC_LOAD=1, 3 cycles each.
- RST asserted during MEM_WR -> MEM_WE=0 that cycle, FETCH next. INSTR_CNT preset to all-ones then one retire -> wraps to 0.

Source files
------------

// File: rtl/mips_main_control_fsm_if.sv
`default_nettype none
// ============================================================================
//  Module      : mips_main_control_fsm_if
//  Description : Control-bus bundle between the multi-cycle main control FSM
//                and the datapath (instruction fields, ALU flags, controls).
//  Revision    : 1.0 - initial release
// ============================================================================
interface mips_main_control_fsm_if #(
  parameter int CNT_WIDTH = 32
);
  logic [5:0]           OPCODE;
  logic [5:0]           FUNCT;
  logic                 ZERO;
  logic                 OVERFLOW;
  logic                 PC_LOAD;
  logic                 IorD;
  logic                 IR_EN;
  logic                 EPC_EN;
  logic [2:0]           PC_SEL;
  logic                 MEM_WE;
  logic                 REG_WE;
  logic                 REG_DST;
  logic                 MEM_TO_REG;
  logic                 ALU_SRC_A;
  logic [1:0]           ALU_SRC_B;
  logic [1:0]           ALU_OP;
  logic                 CAUSE_EN;
  logic                 CAUSE;
  logic [CNT_WIDTH-1:0] INSTR_CNT;

  // Controller side: consumes instruction fields and flags, drives controls.
  modport master (
    input  OPCODE, FUNCT, ZERO, OVERFLOW,
    output PC_LOAD, IorD, IR_EN, EPC_EN, PC_SEL, MEM_WE, REG_WE, REG_DST,
           MEM_TO_REG, ALU_SRC_A, ALU_SRC_B, ALU_OP, CAUSE_EN, CAUSE, INSTR_CNT
  );

  // Datapath side: supplies instruction fields and flags, obeys controls.
  modport slave (
    output OPCODE, FUNCT, ZERO, OVERFLOW,
    input  PC_LOAD, IorD, IR_EN, EPC_EN, PC_SEL, MEM_WE, REG_WE, REG_DST,
           MEM_TO_REG, ALU_SRC_A, ALU_SRC_B, ALU_OP, CAUSE_EN, CAUSE, INSTR_CNT
  );
endinterface
`default_nettype wire

// File: rtl/mips_main_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : mips_main_control_fsm
//  Description : Multi-cycle MIPS main control unit. Sequences fetch, decode,
//                execute, memory and write-back one state per clock, raises
//                undefined-opcode / overflow exceptions and counts retired
//                instructions.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_main_control_fsm #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  mips_main_control_fsm_if.master bus
);

  localparam logic [3:0] c_FETCH     = 4'd0;
  localparam logic [3:0] c_DECODE    = 4'd1;
  localparam logic [3:0] c_MEM_ADDR  = 4'd2;
  localparam logic [3:0] c_MEM_RD    = 4'd3;
  localparam logic [3:0] c_MEM_WB    = 4'd4;
  localparam logic [3:0] c_MEM_WR    = 4'd5;
  localparam logic [3:0] c_EXEC      = 4'd6;
  localparam logic [3:0] c_ALU_WB    = 4'd7;
  localparam logic [3:0] c_ADDI_EXEC = 4'd8;
  localparam logic [3:0] c_ADDI_WB   = 4'd9;
  localparam logic [3:0] c_BRANCH    = 4'd10;
  localparam logic [3:0] c_JUMP      = 4'd11;
  localparam logic [3:0] c_JR        = 4'd12;
  localparam logic [3:0] c_EXC       = 4'd13;

  localparam logic [5:0] c_OP_R    = 6'h00;
  localparam logic [5:0] c_OP_J    = 6'h02;
  localparam logic [5:0] c_OP_BEQ  = 6'h04;
  localparam logic [5:0] c_OP_ADDI = 6'h08;
  localparam logic [5:0] c_OP_LW   = 6'h23;
  localparam logic [5:0] c_OP_SW   = 6'h2B;

  localparam logic [5:0] c_FN_JR  = 6'h08;
  localparam logic [5:0] c_FN_ADD = 6'h20;
  localparam logic [5:0] c_FN_SUB = 6'h22;

  logic [3:0]           r_state;
  logic [3:0]           w_next_state;
  logic                 r_cause;
  logic                 w_cause_next;
  logic                 w_retire;
  logic [CNT_WIDTH-1:0] r_instr_cnt;

  logic       w_pc_load, w_iord, w_ir_en, w_epc_en, w_mem_we, w_reg_we;
  logic       w_reg_dst, w_mem_to_reg, w_alu_src_a, w_cause_en, w_cause_out;
  logic [2:0] w_pc_sel;
  logic [1:0] w_alu_src_b, w_alu_op;

  // Next-state decode; the cause is chosen only on the way into EXC, else held.
  always_comb begin
    w_next_state = c_FETCH;
    w_cause_next = r_cause;
    case (r_state)
      c_FETCH: w_next_state = c_DECODE;
      c_DECODE: begin
        case (bus.OPCODE)
          c_OP_LW, c_OP_SW: w_next_state = c_MEM_ADDR;
          c_OP_R:           w_next_state = (bus.FUNCT == c_FN_JR) ? c_JR : c_EXEC;
          c_OP_BEQ:         w_next_state = c_BRANCH;
          c_OP_J:           w_next_state = c_JUMP;
          c_OP_ADDI:        w_next_state = c_ADDI_EXEC;
          default: begin
            w_next_state = c_EXC;
            w_cause_next = 1'b0;
          end
        endcase
      end
      c_MEM_ADDR: w_next_state = (bus.OPCODE == c_OP_SW) ? c_MEM_WR : c_MEM_RD;
      c_MEM_RD:   w_next_state = c_MEM_WB;
      c_EXEC: begin
        if (bus.OVERFLOW && (bus.FUNCT == c_FN_ADD || bus.FUNCT == c_FN_SUB)) begin
          w_next_state = c_EXC;
          w_cause_next = 1'b1;
        end else begin
          w_next_state = c_ALU_WB;
        end
      end
      c_ADDI_EXEC: begin
        if (bus.OVERFLOW) begin
          w_next_state = c_EXC;
          w_cause_next = 1'b1;
        end else begin
          w_next_state = c_ADDI_WB;
        end
      end
      // Write-back, branch, jump, exception and illegal encodings all return
      // to FETCH, so a corrupted state register recovers in one clock.
      default: w_next_state = c_FETCH;
    endcase
  end

  // States whose exit edge completes an instruction.
  always_comb begin
    case (r_state)
      c_MEM_WB, c_MEM_WR, c_ALU_WB, c_ADDI_WB, c_BRANCH, c_JUMP, c_JR: w_retire = 1'b1;
      default: w_retire = 1'b0;
    endcase
  end

  // State, latched exception cause and retired-instruction counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= c_FETCH;
      r_cause     <= 1'b0;
      r_instr_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      r_cause <= w_cause_next;
      if (w_retire) begin
        r_instr_cnt <= r_instr_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  // Moore control decode; everything is forced low while reset is held.
  always_comb begin
    w_pc_load    = 1'b0;
    w_iord       = 1'b0;
    w_ir_en      = 1'b0;
    w_epc_en     = 1'b0;
    w_pc_sel     = 3'd0;
    w_mem_we     = 1'b0;
    w_reg_we     = 1'b0;
    w_reg_dst    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = 2'd0;
    w_alu_op     = 2'd0;
    w_cause_en   = 1'b0;
    w_cause_out  = 1'b0;
    if (!RST) begin
      case (r_state)
        c_FETCH: begin
          w_ir_en     = 1'b1;
          w_alu_src_b = 2'd1;
          w_pc_load   = 1'b1;
        end
        c_DECODE:   w_alu_src_b = 2'd3;
        c_MEM_ADDR: begin
          w_alu_src_a = 1'b1;
          w_alu_src_b = 2'd2;
        end
        c_MEM_RD:   w_iord = 1'b1;
        c_MEM_WB: begin
          w_reg_we     = 1'b1;
          w_mem_to_reg = 1'b1;
        end
        c_MEM_WR: begin
          w_iord   = 1'b1;
          w_mem_we = 1'b1;
        end
        c_EXEC: begin
          w_alu_src_a = 1'b1;
          w_alu_op    = 2'd2;
        end
        c_ALU_WB: begin
          w_reg_we  = 1'b1;
          w_reg_dst = 1'b1;
        end
        c_ADDI_EXEC: begin
          w_alu_src_a = 1'b1;
          w_alu_src_b = 2'd2;
        end
        c_ADDI_WB:  w_reg_we = 1'b1;
        c_BRANCH: begin
          w_alu_src_a = 1'b1;
          w_alu_op    = 2'd1;
          w_pc_sel    = 3'd1;
          w_pc_load   = bus.ZERO;
        end
        c_JUMP: begin
          w_pc_sel  = 3'd2;
          w_pc_load = 1'b1;
        end
        c_JR: begin
          w_pc_sel  = 3'd3;
          w_pc_load = 1'b1;
        end
        c_EXC: begin
          w_epc_en    = 1'b1;
          w_cause_en  = 1'b1;
          w_cause_out = r_cause;
          w_pc_sel    = 3'd4;
          w_pc_load   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.PC_LOAD    = w_pc_load;
  assign bus.IorD       = w_iord;
  assign bus.IR_EN      = w_ir_en;
  assign bus.EPC_EN     = w_epc_en;
  assign bus.PC_SEL     = w_pc_sel;
  assign bus.MEM_WE     = w_mem_we;
  assign bus.REG_WE     = w_reg_we;
  assign bus.REG_DST    = w_reg_dst;
  assign bus.MEM_TO_REG = w_mem_to_reg;
  assign bus.ALU_SRC_A  = w_alu_src_a;
  assign bus.ALU_SRC_B  = w_alu_src_b;
  assign bus.ALU_OP     = w_alu_op;
  assign bus.CAUSE_EN   = w_cause_en;
  assign bus.CAUSE      = w_cause_out;
  assign bus.INSTR_CNT  = r_instr_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mips_main_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_main_control_fsm
//  Description : Directed self-checking bench for the main control FSM. Each
//                instruction is expanded into its phase list, each phase into
//                its expected control vector; outputs are compared every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_main_control_fsm;

  localparam int CW = 4;

  typedef struct packed {
    logic       pc_load;
    logic       iord;
    logic       ir_en;
    logic       epc_en;
    logic [2:0] pc_sel;
    logic       mem_we;
    logic       reg_we;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       cause_en;
    logic       cause;
  } ctl_t;

  logic CLK;
  logic RST;

  mips_main_control_fsm_if #(.CNT_WIDTH(CW)) bus ();

  mips_main_control_fsm #(.CNT_WIDTH(CW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.master)
  );

  int            checks;
  int            errors;
  int            model_cnt;
  bit            exp_valid;
  string         exp_ph;
  ctl_t          exp_ctl;
  logic [CW-1:0] exp_cnt;
  ctl_t          act_ctl;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected controls for one phase, straight from the per-state table.
  function automatic ctl_t ctl(input string ph, input bit z, input bit c);
    ctl_t v;
    v = '0;
    case (ph)
      "FETCH":     begin v.ir_en = 1; v.alu_src_b = 2'd1; v.pc_load = 1; end
      "DECODE":    v.alu_src_b = 2'd3;
      "MEM_ADDR":  begin v.alu_src_a = 1; v.alu_src_b = 2'd2; end
      "MEM_RD":    v.iord = 1;
      "MEM_WB":    begin v.reg_we = 1; v.mem_to_reg = 1; end
      "MEM_WR":    begin v.iord = 1; v.mem_we = 1; end
      "EXEC":      begin v.alu_src_a = 1; v.alu_op = 2'd2; end
      "ALU_WB":    begin v.reg_we = 1; v.reg_dst = 1; end
      "ADDI_EXEC": begin v.alu_src_a = 1; v.alu_src_b = 2'd2; end
      "ADDI_WB":   v.reg_we = 1;
      "BRANCH":    begin v.alu_src_a = 1; v.alu_op = 2'd1; v.pc_sel = 3'd1; v.pc_load = z; end
      "JUMP":      begin v.pc_sel = 3'd2; v.pc_load = 1; end
      "JR":        begin v.pc_sel = 3'd3; v.pc_load = 1; end
      "EXC":       begin v.epc_en = 1; v.cause_en = 1; v.cause = c; v.pc_sel = 3'd4; v.pc_load = 1; end
      default:     v = '0;
    endcase
    return v;
  endfunction

  // Per-cycle comparison of all DUT outputs against the current expectation.
  always @(negedge CLK) begin
    if (exp_valid) begin
      act_ctl = {bus.PC_LOAD, bus.IorD, bus.IR_EN, bus.EPC_EN, bus.PC_SEL,
                 bus.MEM_WE, bus.REG_WE, bus.REG_DST, bus.MEM_TO_REG,
                 bus.ALU_SRC_A, bus.ALU_SRC_B, bus.ALU_OP, bus.CAUSE_EN, bus.CAUSE};
      checks++;
      if (act_ctl !== exp_ctl) begin
        errors++;
        $display("FAIL ctl[%s] t=%0t: got %b expected %b", exp_ph, $time, act_ctl, exp_ctl);
      end
      checks++;
      if (bus.INSTR_CNT !== exp_cnt) begin
        errors++;
        $display("FAIL instr_cnt[%s] t=%0t: got %0d expected %0d", exp_ph, $time, bus.INSTR_CNT, exp_cnt);
      end
    end
  end

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
      RST       = 1'b1;
      exp_ph    = "RESET";
      exp_ctl   = '0;
      exp_cnt   = '0;
      exp_valid = 1'b1;
    end
    model_cnt = 0;
  endtask

  // Runs one instruction. rst_at >= 0 asserts RST in that phase instead;
  // pre_cnt >= 0 is a hand-computed count expected during FETCH.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input bit z,
                           input bit ovf, input int rst_at, input int pre_cnt);
    string ph[$];
    bit    cause;
    bit    retires;
    bit    aborted;
    ph.push_back("FETCH");
    ph.push_back("DECODE");
    cause   = 1'b0;
    retires = 1'b1;
    aborted = 1'b0;
    case (op)
      6'h23: begin ph.push_back("MEM_ADDR"); ph.push_back("MEM_RD"); ph.push_back("MEM_WB"); end
      6'h2B: begin ph.push_back("MEM_ADDR"); ph.push_back("MEM_WR"); end
      6'h04: ph.push_back("BRANCH");
      6'h02: ph.push_back("JUMP");
      6'h00: begin
        if (fn == 6'h08) ph.push_back("JR");
        else begin
          ph.push_back("EXEC");
          if (ovf && (fn == 6'h20 || fn == 6'h22)) begin
            ph.push_back("EXC"); cause = 1'b1; retires = 1'b0;
          end else ph.push_back("ALU_WB");
        end
      end
      6'h08: begin
        ph.push_back("ADDI_EXEC");
        if (ovf) begin ph.push_back("EXC"); cause = 1'b1; retires = 1'b0; end
        else ph.push_back("ADDI_WB");
      end
      default: begin ph.push_back("EXC"); cause = 1'b0; retires = 1'b0; end
    endcase
    for (int i = 0; i < ph.size() && !aborted; i++) begin
      @(posedge CLK); #1;
      bus.OPCODE   = op;
      bus.FUNCT    = fn;
      bus.ZERO     = z;
      bus.OVERFLOW = ovf;
      exp_cnt      = model_cnt[CW-1:0];
      exp_valid    = 1'b1;
      if (i == rst_at) begin
        RST     = 1'b1;
        exp_ph  = "RESET";
        exp_ctl = '0;
        aborted = 1'b1;
      end else begin
        RST     = 1'b0;
        exp_ph  = ph[i];
        exp_ctl = ctl(ph[i], z, cause);
      end
      if (i == 0 && pre_cnt >= 0) begin
        @(negedge CLK); #1;
        check("cnt_literal", 32'(bus.INSTR_CNT), 32'(pre_cnt));
      end
    end
    if (aborted) model_cnt = 0;
    else if (retires) model_cnt = (model_cnt + 1) % (1 << CW);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    model_cnt    = 0;
    exp_valid    = 1'b0;
    exp_ph       = "IDLE";
    exp_ctl      = '0;
    exp_cnt      = '0;
    RST          = 1'b1;
    bus.OPCODE   = 6'h00;
    bus.FUNCT    = 6'h00;
    bus.ZERO     = 1'b0;
    bus.OVERFLOW = 1'b0;
    repeat (2) @(posedge CLK);
    reset_cycles(2);

    run_instr(6'h23, 6'h00, 1'b0, 1'b0, -1, 0);  // lw
    run_instr(6'h04, 6'h00, 1'b0, 1'b0, -1, 1);  // beq not taken
    run_instr(6'h04, 6'h00, 1'b1, 1'b0, -1, 2);  // beq taken
    run_instr(6'h00, 6'h20, 1'b0, 1'b1, -1, 3);  // add overflow -> EXC cause 1
    run_instr(6'h3F, 6'h00, 1'b0, 1'b0, -1, 3);  // undefined -> EXC cause 0
    run_instr(6'h02, 6'h00, 1'b0, 1'b0, -1, 3);  // j
    run_instr(6'h00, 6'h08, 1'b0, 1'b0, -1, 4);  // jr
    run_instr(6'h00, 6'h22, 1'b0, 1'b0, -1, 5);  // sub, no overflow
    run_instr(6'h00, 6'h22, 1'b0, 1'b1, -1, 6);  // sub overflow -> EXC
    run_instr(6'h00, 6'h24, 1'b0, 1'b1, -1, 6);  // and: overflow ignored
    run_instr(6'h08, 6'h00, 1'b0, 1'b0, -1, 7);  // addi
    run_instr(6'h08, 6'h00, 1'b0, 1'b1, -1, 8);  // addi overflow -> EXC
    run_instr(6'h2B, 6'h00, 1'b0, 1'b0, -1, 8);  // sw
    run_instr(6'h2B, 6'h00, 1'b0, 1'b0,  3, 9);  // sw, reset during MEM_WR
    run_instr(6'h23, 6'h00, 1'b0, 1'b0, -1, 0);  // lw after reset
    for (int i = 0; i < 16; i++) begin
      run_instr(6'h02, 6'h00, 1'b0, 1'b0, -1, (1 + i) % 16);  // counter wraps
    end
    run_instr(6'h23, 6'h00, 1'b0, 1'b0, -1, 1);

    @(posedge CLK); #1;
    exp_valid = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
